ps2_scancode_rx: RTL

//  PS/2 keyboard receiver running on the system clock. Oversamples ps2_clk/ps2_data and checks full
//  11-bit frames (start/parity/stop, timeout). Folds E0/F0 prefixes into key events and queues them
//  in a FIFO with valid/ready. Tracks LShift+Alt to toggle the RU/EN layout flag.

---
 rtl/ps2_scancode_rx_pkg.sv | 18 +
 rtl/ps2_scancode_rx_fifo.sv | 57 +++++
 rtl/ps2_scancode_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
// Event words are packed as {ext, brk, code}.
package ps2_scancode_rx_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] KEY_LSHIFT = 8'h12;
   localparam logic [7:0] KEY_ALT    = 8'h11;
   localparam int         EVT_W      = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

endpackage

// File: rtl/ps2_scancode_rx_fifo.sv
// Show-ahead synchronous FIFO for key events.
// A push arriving while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
   import ps2_scancode_rx_pkg::*;
#(
   parameter int WIDTH = EVT_W,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & full & ~pop_ok;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, check 11-bit frames,
// fold E0/F0 prefixes into key events, queue them, and track the RU/EN layout toggle.
module ps2_scancode_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic                          evt_ext,
   output logic                          evt_brk,
   output logic [7:0]                    evt_code,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          layout_en,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_timeout,
   output logic                          ovf
);

   localparam int FCW = $clog2(FILTER_LEN);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);

   logic             clk_meta, clk_sync, data_meta, data_sync;
   logic             filt_clk, filt_clk_d;
   logic [FCW-1:0]   filt_cnt;
   logic             fall;

   frame_state_t     state, state_nxt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             par_fault;
   logic [TW-1:0]    tmo_cnt;
   logic             tmo_expired;

   logic             byte_valid, frame_bad, parity_bad, timeout_hit;
   logic             ext_pend, brk_pend, shift_held;
   logic             key_push;

   logic [EVT_W-1:0] fifo_rdata;
   logic             fifo_full, fifo_empty, fifo_drop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= ps2_clk;
         clk_sync  <= clk_meta;
         data_meta <= ps2_data;
         data_sync <= data_meta;
      end
   end

   // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         filt_clk_d <= filt_clk;
         if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall        = filt_clk_d & ~filt_clk;
   assign tmo_expired = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt   = state;
      byte_valid  = 1'b0;
      frame_bad   = 1'b0;
      parity_bad  = 1'b0;
      timeout_hit = 1'b0;
      if (state != ST_IDLE && tmo_expired && !fall) begin
         timeout_hit = 1'b1;
         state_nxt   = ST_IDLE;
      end else if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!data_sync) state_nxt = ST_DATA;
               else            frame_bad = 1'b1;
            end
            ST_DATA: begin
               if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
            end
            ST_PARITY: state_nxt = ST_STOP;
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (!data_sync)     frame_bad  = 1'b1;
               else if (par_fault) parity_bad = 1'b1;
               else                byte_valid = 1'b1;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_fault <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE || fall)  tmo_cnt <= '0;
         else if (!tmo_expired)         tmo_cnt <= tmo_cnt + 1'b1;
         if (fall) begin
            case (state)
               ST_IDLE: begin
                  bit_cnt   <= '0;
                  par_fault <= 1'b0;
               end
               ST_DATA: begin
                  shift_reg <= {data_sync, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 1'b1;
               end
               ST_PARITY: par_fault <= ~(^{shift_reg, data_sync});
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_frame   <= 1'b0;
         err_parity  <= 1'b0;
         err_timeout <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         err_frame   <= frame_bad;
         err_parity  <= parity_bad;
         err_timeout <= timeout_hit;
         ovf         <= fifo_drop;
      end
   end

   assign key_push = byte_valid && (shift_reg != PS2_EXT) && (shift_reg != PS2_BRK);

   // Layout tracking sees every key event, even one the full FIFO has to drop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
         shift_held <= 1'b0;
         layout_en  <= 1'b0;
      end else if (byte_valid) begin
         if (shift_reg == PS2_EXT) begin
            ext_pend <= 1'b1;
         end else if (shift_reg == PS2_BRK) begin
            brk_pend <= 1'b1;
         end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (!ext_pend && shift_reg == KEY_LSHIFT)
               shift_held <= ~brk_pend;
            if (!ext_pend && !brk_pend && shift_reg == KEY_ALT && shift_held)
               layout_en <= ~layout_en;
         end
      end else if (frame_bad || parity_bad || timeout_hit) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (key_push),
      .pop   (evt_ready),
      .wdata ({ext_pend, brk_pend, shift_reg}),
      .rdata (fifo_rdata),
      .count (evt_count),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   // Storage is not reset, so the head fields are forced to zero while empty.
   assign evt_valid = ~fifo_empty;
   assign {evt_ext, evt_brk, evt_code} = fifo_empty ? '0 : fifo_rdata;

endmodule
